// File: rtl/div_clk32m768_pkg.sv
// ============================================================================
// Module      : div_clk32m768_pkg
// Description : Shared constants for the 32.768 MHz power-of-two clock divider
//               and the Tx/Rx rate calculations that depend on it.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package div_clk32m768_pkg;

    localparam int          DIV_STAGES   = 15;
    localparam int unsigned BASE_FREQ_HZ = 32'd32768000;

    // Nominal frequency of the divide-by-2^k output.
    function automatic int unsigned div_freq_hz(input int unsigned k);
        return BASE_FREQ_HZ >> k;
    endfunction

endpackage

`default_nettype wire

// File: rtl/div_clk32m768.sv
// ============================================================================
// Module      : div_clk32m768
// Description : Fifteen phase-aligned 50 % square waves (/2 .. /32768) taken
//               straight from the bits of one free-running down-counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_clk32m768
    import div_clk32m768_pkg::*;
(
    input  logic clk32M768,
    input  logic rst_32M768,
    output logic clk16M384,
    output logic clk8M192,
    output logic clk4M096,
    output logic clk2M048,
    output logic clk1M024,
    output logic clk512K,
    output logic clk256K,
    output logic clk128K,
    output logic clk64K,
    output logic clk32K,
    output logic clk16K,
    output logic clk8K,
    output logic clk4K,
    output logic clk2K,
    output logic clk1K
);

    logic [DIV_STAGES-1:0] r_cnt;

    // Counting down makes every bit rise together when the low bits wrap
    // from zero to all-ones, which is what keeps the rising edges aligned.
    always_ff @(posedge clk32M768 or posedge rst_32M768) begin
        if (rst_32M768) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign clk16M384 = r_cnt[0];
    assign clk8M192  = r_cnt[1];
    assign clk4M096  = r_cnt[2];
    assign clk2M048  = r_cnt[3];
    assign clk1M024  = r_cnt[4];
    assign clk512K   = r_cnt[5];
    assign clk256K   = r_cnt[6];
    assign clk128K   = r_cnt[7];
    assign clk64K    = r_cnt[8];
    assign clk32K    = r_cnt[9];
    assign clk16K    = r_cnt[10];
    assign clk8K     = r_cnt[11];
    assign clk4K     = r_cnt[12];
    assign clk2K     = r_cnt[13];
    assign clk1K     = r_cnt[14];

endmodule

`default_nettype wire

// File: tb/tb_div_clk32m768.sv
// ============================================================================
// Module      : tb_div_clk32m768
// Description : Scoreboard bench for div_clk32m768: expected output vectors
//               are queued by the stimulus and compared by a monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div_clk32m768;

    typedef struct {
        int          tag;
        logic [14:0] exp;
    } exp_t;

    logic clk32M768;
    logic rst_32M768;
    logic clk16M384, clk8M192, clk4M096, clk2M048, clk1M024;
    logic clk512K, clk256K, clk128K, clk64K, clk32K;
    logic clk16K, clk8K, clk4K, clk2K, clk1K;
    logic [14:0] w_out;

    exp_t q_exp[$];
    int   n_cmp;
    int   n_err;
    int   cyc;
    bit   measure;

    int   first_rise [15];
    int   period     [15];
    int   high_cnt   [15];
    logic [14:0] prev_out;

    div_clk32m768 u_dut (
        .clk32M768  (clk32M768),
        .rst_32M768 (rst_32M768),
        .clk16M384  (clk16M384),
        .clk8M192   (clk8M192),
        .clk4M096   (clk4M096),
        .clk2M048   (clk2M048),
        .clk1M024   (clk1M024),
        .clk512K    (clk512K),
        .clk256K    (clk256K),
        .clk128K    (clk128K),
        .clk64K     (clk64K),
        .clk32K     (clk32K),
        .clk16K     (clk16K),
        .clk8K      (clk8K),
        .clk4K      (clk4K),
        .clk2K      (clk2K),
        .clk1K      (clk1K)
    );

    // Bit k-1 is the divide-by-2^k output.
    assign w_out = {clk1K, clk2K, clk4K, clk8K, clk16K, clk32K, clk64K, clk128K,
                    clk256K, clk512K, clk1M024, clk2M048, clk4M096, clk8M192, clk16M384};

    initial begin
        clk32M768 = 1'b0;
        forever #5 clk32M768 = ~clk32M768;
    end

    // Expected outputs n edges after release: counter = (0 - n) mod 2^15.
    function automatic logic [14:0] exp_at(input int n);
        int v;
        v = (32768 - (n % 32768)) % 32768;
        return v[14:0];
    endfunction

    function automatic bit want_check(input int n);
        return (n <= 70) || (n % 997 == 0) || (n >= 32760);
    endfunction

    task automatic push(input int tag, input logic [14:0] e);
        exp_t it;
        it.tag = tag;
        it.exp = e;
        q_exp.push_back(it);
    endtask

    task automatic check_int(input string name, input int k, input int got, input int req);
        n_cmp++;
        if (got != req) begin
            n_err++;
            $display("FAIL %s div2^%0d: got %0d required %0d", name, k, got, req);
        end
    endtask

    // Monitor: pops one expectation per falling edge and gathers frame stats.
    initial begin
        exp_t it;
        prev_out = '0;
        forever begin
            @(negedge clk32M768);
            if (q_exp.size() > 0) begin
                it = q_exp.pop_front();
                n_cmp++;
                if (w_out !== it.exp) begin
                    n_err++;
                    $display("FAIL vec tag=%0d: got %h required %h", it.tag, w_out, it.exp);
                end
            end
            if (measure && cyc >= 1) begin
                for (int b = 0; b < 15; b++) begin
                    if (w_out[b] && !prev_out[b]) begin
                        if (first_rise[b] < 0)
                            first_rise[b] = cyc;
                        else if (period[b] == 0)
                            period[b] = cyc - first_rise[b];
                    end
                    if (w_out[b] && cyc <= 32768)
                        high_cnt[b]++;
                end
                prev_out = w_out;
            end
        end
    end

    // Stimulus
    initial begin
        n_cmp   = 0;
        n_err   = 0;
        cyc     = 0;
        measure = 1'b0;
        for (int b = 0; b < 15; b++) begin
            first_rise[b] = -1;
            period[b]     = 0;
            high_cnt[b]   = 0;
        end
        rst_32M768 = 1'b1;

        // Reset held: outputs stay low.
        for (int i = 0; i < 128; i++) begin
            @(posedge clk32M768);
            #1 push(-1, 15'h0000);
        end
        #1 rst_32M768 = 1'b0;

        // Full frame after release, with period/duty measurement.
        measure = 1'b1;
        for (int n = 1; n <= 32772; n++) begin
            @(posedge clk32M768);
            cyc = n;
            if (n == 1)     push(n, 15'h7FFF);
            else if (n == 2) push(n, 15'h7FFE);
            else if (n == 3) push(n, 15'h7FFD);
            else if (n == 32768) push(n, 15'h0000);
            else if (n == 32769) push(n, 15'h7FFF);
            else if (want_check(n)) push(n, exp_at(n));
        end
        @(negedge clk32M768);
        measure = 1'b0;
        for (int b = 0; b < 15; b++) begin
            check_int("period", b + 1, period[b], 2 ** (b + 1));
            check_int("high", b + 1, high_cnt[b], 16384);
        end

        // Second run, asynchronous reset between edges at cycle 1000.
        @(posedge clk32M768);
        #1 rst_32M768 = 1'b1;
        cyc = 0;
        push(-2, 15'h0000);
        @(posedge clk32M768);
        #1 rst_32M768 = 1'b0;
        for (int n = 1; n <= 1000; n++) begin
            @(posedge clk32M768);
            cyc = n;
            if (n < 1000 && (n <= 40 || n == 999)) push(n, exp_at(n));
        end
        #2 rst_32M768 = 1'b1;
        push(-3, 15'h0000);
        cyc = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk32M768);
            #1 push(-4, 15'h0000);
        end
        #1 rst_32M768 = 1'b0;
        for (int n = 1; n <= 70; n++) begin
            @(posedge clk32M768);
            cyc = n;
            push(n, exp_at(n));
        end

        @(negedge clk32M768);
        #1;
        n_cmp++;
        if (q_exp.size() != 0) begin
            n_err++;
            $display("FAIL queue_drain: got %0d left required 0", q_exp.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
